// File: rtl/jn_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : jn_phase_sched
// Brief    : Single-junction phase scheduler. Round-robin green arbitration
//            over four approaches (N,S,E,W) with min/max green timers, an
//            all-red clearance interval and an emergency-vehicle override.
//            Optional macro JN_YELLOW_EN compiles in a yellow phase between
//            every green and the following all-red interval.
// Revision : 1.0 - initial release
// ============================================================================
module jn_phase_sched #(
    parameter int MIN_GRN = 4,
    parameter int MAX_GRN = 12,
    parameter int YLW_T   = 3,
    parameter int CLR_T   = 2,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emg_vld,
    input  logic [1:0] emg_dir,
    output logic [2:0] l_n,
    output logic [2:0] l_s,
    output logic [2:0] l_e,
    output logic [2:0] l_w,
    output logic [3:0] gnt
);

    localparam logic [1:0] c_st_all_red = 2'd0;
    localparam logic [1:0] c_st_green   = 2'd1;
`ifdef JN_YELLOW_EN
    localparam logic [1:0] c_st_yellow  = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_ALL_RED = c_st_all_red,
        ST_GREEN   = c_st_green
`ifdef JN_YELLOW_EN
        , ST_YELLOW = c_st_yellow
`endif
    } state_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_min = CNT_W'(MIN_GRN);
    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_GRN);
    localparam logic [CNT_W-1:0] c_clr = CNT_W'(CLR_T);
`ifdef JN_YELLOW_EN
    localparam logic [CNT_W-1:0] c_ylw = CNT_W'(YLW_T);
    localparam logic [2:0]       c_yel = 3'b010;
`endif
    localparam logic [2:0]       c_red = 3'b100;
    localparam logic [2:0]       c_grn = 3'b001;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_cur, w_cur_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0][2:0]  r_lamp, w_lamp_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;

    logic             w_win_vld;
    logic [1:0]       w_win;
    logic [3:0]       w_cur_oh;
    logic             w_other;
    logic             w_emg_pre;
    logic             w_emg_hold;
    logic             w_exit;

    // Winner selection: emergency direction first, else first request after ptr
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = r_ptr;
        if (emg_vld) begin
            w_win_vld = 1'b1;
            w_win     = emg_dir;
        end else begin
            // Descending scan so the nearest candidate after ptr overwrites last
            for (int i = 4; i >= 1; i--) begin
                if (req[r_ptr + 2'(i)]) begin
                    w_win_vld = 1'b1;
                    w_win     = r_ptr + 2'(i);
                end
            end
        end
    end

    // Green termination conditions for the currently granted approach
    always_comb begin
        w_cur_oh   = 4'b0001 << r_cur;
        w_other    = |(req & ~w_cur_oh);
        w_emg_pre  = emg_vld && (emg_dir != r_cur);
        w_emg_hold = emg_vld && (emg_dir == r_cur);
        w_exit     = w_emg_pre ||
                     (!w_emg_hold && w_other &&
                      ((r_cnt >= c_max) || ((r_cnt >= c_min) && !req[r_cur])));
    end

    // Next-state, grant pointer and phase timer
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ALL_RED: begin
                if (r_cnt >= c_clr) begin
                    // Clearance satisfied; timer stays saturated while idle
                    if (w_win_vld) begin
                        w_state_nxt = ST_GREEN;
                        w_cur_nxt   = w_win;
                        w_ptr_nxt   = w_win;
                        w_cnt_nxt   = c_one;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            ST_GREEN: begin
                if (w_exit) begin
`ifdef JN_YELLOW_EN
                    w_state_nxt = ST_YELLOW;
`else
                    w_state_nxt = ST_ALL_RED;
`endif
                    w_cnt_nxt   = c_one;
                end else if (r_cnt < c_max) begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
`ifdef JN_YELLOW_EN
            ST_YELLOW: begin
                if (r_cnt >= c_ylw) begin
                    w_state_nxt = ST_ALL_RED;
                    w_cnt_nxt   = c_one;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_ALL_RED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Lamp and grant values derived from the upcoming state so outputs are registered
    always_comb begin
        w_gnt_nxt = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            w_lamp_nxt[d] = c_red;
        end
        if (w_state_nxt == ST_GREEN) begin
            w_lamp_nxt[w_cur_nxt] = c_grn;
            w_gnt_nxt             = 4'b0001 << w_cur_nxt;
        end
`ifdef JN_YELLOW_EN
        if (w_state_nxt == ST_YELLOW) begin
            w_lamp_nxt[w_cur_nxt] = c_yel;
        end
`endif
    end

    // State, timer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ALL_RED;
            r_cur   <= 2'd3;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_lamp  <= {4{c_red}};
            r_gnt   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lamp  <= w_lamp_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign l_n = r_lamp[0];
    assign l_s = r_lamp[1];
    assign l_e = r_lamp[2];
    assign l_w = r_lamp[3];
    assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_jn_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_jn_phase_sched
// Brief    : Self-checking bench for jn_phase_sched. A phase-level reference
//            model predicts lamps and grant every cycle under directed and
//            random request/emergency stimulus. Honours JN_YELLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jn_phase_sched;

    localparam int MIN_GRN = 4;
    localparam int MAX_GRN = 12;
    localparam int YLW_T   = 3;
    localparam int CLR_T   = 2;
    localparam int CNT_W   = 8;
`ifdef JN_YELLOW_EN
    localparam bit YEL_ON  = 1'b1;
`else
    localparam bit YEL_ON  = 1'b0;
`endif

    localparam int PH_RED = 0;
    localparam int PH_GRN = 1;
    localparam int PH_YEL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       emg_vld = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic [2:0] l_n, l_s, l_e, l_w;
    logic [3:0] gnt;
    logic [15:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, cycles elapsed in phase, approach shown, last served
    int m_phase = PH_RED;
    int m_el    = 0;
    int m_dir   = 3;
    int m_ptr   = 3;

    jn_phase_sched #(
        .MIN_GRN (MIN_GRN),
        .MAX_GRN (MAX_GRN),
        .YLW_T   (YLW_T),
        .CLR_T   (CLR_T),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .emg_vld (emg_vld),
        .emg_dir (emg_dir),
        .l_n     (l_n),
        .l_s     (l_s),
        .l_e     (l_e),
        .l_w     (l_w),
        .gnt     (gnt)
    );

    always #5 clk = ~clk;

    assign obs = {l_n, l_s, l_e, l_w, gnt};

    // Advance the model by one clock using the inputs present before the edge
    task automatic m_step();
        int  w;
        bit  found;
        bit  others;
        bit  leave;
        if (rst) begin
            m_phase = PH_RED;
            m_el    = 0;
            m_dir   = 3;
            m_ptr   = 3;
            return;
        end
        case (m_phase)
            PH_RED: begin
                found = 1'b0;
                w     = 0;
                if (m_el >= CLR_T) begin
                    if (emg_vld) begin
                        found = 1'b1;
                        w     = int'(emg_dir);
                    end else begin
                        for (int k = 1; k <= 4; k++) begin
                            if (!found && req[(m_ptr + k) % 4]) begin
                                found = 1'b1;
                                w     = (m_ptr + k) % 4;
                            end
                        end
                    end
                end
                if (found) begin
                    m_phase = PH_GRN;
                    m_dir   = w;
                    m_ptr   = w;
                    m_el    = 1;
                end else begin
                    m_el = m_el + 1;
                end
            end
            PH_GRN: begin
                others = 1'b0;
                for (int d = 0; d < 4; d++) begin
                    if (d != m_dir && req[d]) others = 1'b1;
                end
                if (emg_vld && int'(emg_dir) != m_dir)
                    leave = 1'b1;
                else if (emg_vld)
                    leave = 1'b0;
                else
                    leave = others && (m_el >= MAX_GRN || (m_el >= MIN_GRN && !req[m_dir]));
                if (leave) begin
                    m_phase = YEL_ON ? PH_YEL : PH_RED;
                    m_el    = 1;
                end else begin
                    m_el = m_el + 1;
                end
            end
            default: begin
                if (m_el >= YLW_T) begin
                    m_phase = PH_RED;
                    m_el    = 1;
                end else begin
                    m_el = m_el + 1;
                end
            end
        endcase
    endtask

    function automatic logic [15:0] m_expect();
        logic [2:0] lamp [4];
        logic [3:0] g;
        g = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            if (d == m_dir && m_phase == PH_GRN)      lamp[d] = 3'b001;
            else if (d == m_dir && m_phase == PH_YEL) lamp[d] = 3'b010;
            else                                      lamp[d] = 3'b100;
        end
        if (m_phase == PH_GRN) g = 4'(1 << m_dir);
        return {lamp[0], lamp[1], lamp[2], lamp[3], g};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) begin
            m_step();
            @(posedge clk);
            #1;
            check(tag, m_expect());
        end
    endtask

    initial begin
        // Reset with no requests: everything red and staying red
        rst = 1'b1; req = 4'b0000;
        run("reset", 2);
        check("reset_lit", 16'h9240);
        rst = 1'b0;
        run("idle", 20);
        check("idle_lit", 16'h9240);

        // Single north request from release: green on the third edge, held
        rst = 1'b1; run("rst_single", 2);
        rst = 1'b0; req = 4'b0001;
        run("single_clr", 2);
        check("single_edge2_lit", 16'h9240);
        run("single_clr", 1);
        check("single_edge3_lit", 16'h3241);
        run("single_hold", 55);
        check("single_hold_lit", 16'h3241);

        // All approaches requesting: round-robin with max-green terminations
        rst = 1'b1; run("rst_rr", 2);
        rst = 1'b0; req = 4'b1111;
        run("round_robin", 80);

        // Gap-out: north drops in its second green cycle while east waits
        rst = 1'b1; run("rst_gap", 2);
        rst = 1'b0; req = 4'b0001;
        run("gap_clr", 3);
        check("gap_green_lit", 16'h3241);
        run("gap_green", 1);
        req = 4'b0100;
        run("gap_out", 20);

        // Emergency preempting west in favour of north, then held
        rst = 1'b1; req = 4'b0000; run("rst_emg", 2);
        rst = 1'b0; req = 4'b1000;
        run("emg_pre", 3);
        check("emg_w_lit", 16'h9218);
        run("emg_pre", 2);
        emg_vld = 1'b1; emg_dir = 2'd0; req = 4'b1110;
        run("emg_hold", 40);
        emg_vld = 1'b0;
        run("emg_release", 30);

        // Emergency and request on the same approach together
        rst = 1'b1; req = 4'b0000; run("rst_same", 2);
        rst = 1'b0; req = 4'b0100; emg_vld = 1'b1; emg_dir = 2'd2;
        run("emg_same", 10);
        emg_vld = 1'b0; req = 4'b0011;
        run("emg_same_after", 30);

`ifdef JN_YELLOW_EN
        // Reset landing in the middle of a yellow interval
        rst = 1'b1; req = 4'b0000; run("rst_ylw", 2);
        rst = 1'b0; req = 4'b0001;
        run("ylw_clr", 3);
        req = 4'b0010;
        run("ylw_green", 4);
        run("ylw_y1", 1);
        rst = 1'b1;
        run("ylw_rst", 1);
        check("ylw_rst_lit", 16'h9240);
        rst = 1'b0; req = 4'b1000;
        run("ylw_after", 3);
        check("ylw_w_lit", 16'h9218);
        run("ylw_after", 10);
`endif

        // Randomised traffic with sporadic emergencies and resets
        rst = 1'b1; req = 4'b0000; emg_vld = 1'b0; run("rst_rand", 2);
        rst = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                emg_vld = ~emg_vld;
                emg_dir = 2'($urandom);
            end
            rst = ($urandom_range(0, 249) == 0);
            run("random", 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
